// File: rtl/branch_ctrl.sv
// branch_ctrl
//
// ID-stage branch resolution controller for a 5-stage MIPS pipeline.
// Evaluates conditional branches and j/jal in ID. Forwards branch operands
// from the MEM-stage ALU result. Stalls IF/ID and injects EX bubbles while
// an operand is still in flight. Issues a one-cycle registered PC redirect
// with IF/ID flush control. Keeps saturating branch statistics.
//
// Parameters
//   DELAY_SLOT  1: instruction at branch PC+4 executes; 0: it is flushed
//   CNT_W       width of the statistics counters
//
// Ports
//   clk, rst                core clock (rising edge), async active-high reset
//   id_valid                ID holds a valid instruction
//   branch_cond[2:0]        0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz,
//                           6 bgez, 7 none
//   jump                    unconditional j/jal in ID
//   id_pc4[31:0]            PC+4 of the ID instruction
//   imm[15:0]               branch word offset
//   jaddr[25:0]             jump index
//   rs, rt[4:0]             source register numbers
//   rf_a, rf_b[31:0]        register file read data
//   ex_wr_en, ex_is_load, ex_wr_addr                   EX-stage writer
//   mem_wr_en, mem_is_load, mem_wr_addr, mem_result    MEM-stage writer
//   stall                   hold PC and IF/ID
//   bubble_ex               load a NOP into ID/EX
//   pc_redirect             load pc_target into PC at the next edge
//   pc_target[31:0]         redirect address
//   flush_if                squash the IF/ID register input
//   flush_id                squash the ID/EX register input (no delay slot)
//   br_cnt, taken_cnt       resolved conditional branches, taken
//                           branches plus jumps
module branch_ctrl #(
  parameter bit          DELAY_SLOT = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       branch_cond,
  input  logic             jump,
  input  logic [31:0]      id_pc4,
  input  logic [15:0]      imm,
  input  logic [25:0]      jaddr,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [31:0]      rf_a,
  input  logic [31:0]      rf_b,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wr_addr,
  input  logic             mem_wr_en,
  input  logic             mem_is_load,
  input  logic [4:0]       mem_wr_addr,
  input  logic [31:0]      mem_result,
  output logic             stall,
  output logic             bubble_ex,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StStall,
    StRedirect
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [31:0]      target_q;
  logic             redirect_q;
  logic             flush_if_q;
  logic             flush_id_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  // Request decode; a jump wins over a simultaneous branch.
  logic cond_valid;
  logic j_req;
  logic br_req;

  assign cond_valid = (branch_cond != 3'd0) && (branch_cond != 3'd7);
  assign j_req      = id_valid & jump;
  assign br_req     = id_valid & cond_valid & ~jump;

  // Only beq/bne read rt; the single-operand compares look at rs alone.
  logic use_rt;
  assign use_rt = (branch_cond == 3'd1) || (branch_cond == 3'd2);

  // Operand forwarding from the MEM-stage ALU result. A MEM load has no data
  // yet, so it is handled as a hazard instead of being forwarded.
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign fwd_a = mem_wr_en & ~mem_is_load & (mem_wr_addr == rs) & (rs != 5'd0);
  assign fwd_b = mem_wr_en & ~mem_is_load & (mem_wr_addr == rt) & (rt != 5'd0);
  assign op_a  = fwd_a ? mem_result : rf_a;
  assign op_b  = fwd_b ? mem_result : rf_b;

  // Hazard depth per operand: EX load needs 2 cycles, EX ALU or MEM load 1.
  logic       ex_hit_a;
  logic       ex_hit_b;
  logic       mem_ld_hit_a;
  logic       mem_ld_hit_b;
  logic [1:0] n_a;
  logic [1:0] n_b;
  logic [1:0] n_stall;

  assign ex_hit_a     = ex_wr_en & (ex_wr_addr == rs) & (rs != 5'd0);
  assign ex_hit_b     = ex_wr_en & (ex_wr_addr == rt) & (rt != 5'd0) & use_rt;
  assign mem_ld_hit_a = mem_wr_en & mem_is_load & (mem_wr_addr == rs) & (rs != 5'd0);
  assign mem_ld_hit_b = mem_wr_en & mem_is_load & (mem_wr_addr == rt) & (rt != 5'd0) & use_rt;

  always_comb begin
    n_a = 2'd0;
    if (ex_hit_a) begin
      n_a = ex_is_load ? 2'd2 : 2'd1;
    end else if (mem_ld_hit_a) begin
      n_a = 2'd1;
    end
    n_b = 2'd0;
    if (ex_hit_b) begin
      n_b = ex_is_load ? 2'd2 : 2'd1;
    end else if (mem_ld_hit_b) begin
      n_b = 2'd1;
    end
    n_stall = (n_a > n_b) ? n_a : n_b;
  end

  // Branch condition evaluation on forwarded operands.
  logic a_zero;
  logic taken;

  assign a_zero = (op_a == 32'd0);

  always_comb begin
    taken = 1'b0;
    case (branch_cond)
      3'd1:    taken = (op_a == op_b);
      3'd2:    taken = (op_a != op_b);
      3'd3:    taken = op_a[31] | a_zero;
      3'd4:    taken = ~op_a[31] & ~a_zero;
      3'd5:    taken = op_a[31];
      3'd6:    taken = ~op_a[31];
      default: taken = 1'b0;
    endcase
  end

  // Redirect targets; the branch add wraps modulo 2^32.
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign br_target = id_pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_target  = {id_pc4[31:28], jaddr, 2'b00};

  // In IDLE the stall is combinational from the current request; in STALL it
  // comes from the registered state. Reset forces both low immediately.
  logic idle_stall;

  assign idle_stall = (state_q == StIdle) & br_req & (n_stall != 2'd0);

  always_comb begin
    stall     = 1'b0;
    bubble_ex = 1'b0;
    if (!rst && (idle_stall || (state_q == StStall))) begin
      stall     = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      target_q    <= 32'd0;
      redirect_q  <= 1'b0;
      flush_if_q  <= 1'b0;
      flush_id_q  <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      redirect_q <= 1'b0;
      flush_if_q <= 1'b0;
      flush_id_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (j_req) begin
            if (taken_cnt_q != CntMax) taken_cnt_q <= taken_cnt_q + CntOne;
            target_q   <= j_target;
            state_q    <= StRedirect;
            redirect_q <= 1'b1;
            flush_if_q <= 1'b1;
            flush_id_q <= ~DELAY_SLOT;
          end else if (br_req) begin
            if (n_stall != 2'd0) begin
              cnt_q <= n_stall - 2'd1;
              // With one cycle left the hazard is simply re-checked in IDLE.
              if (n_stall == 2'd2) state_q <= StStall;
            end else begin
              if (br_cnt_q != CntMax) br_cnt_q <= br_cnt_q + CntOne;
              if (taken) begin
                if (taken_cnt_q != CntMax) taken_cnt_q <= taken_cnt_q + CntOne;
                target_q   <= br_target;
                state_q    <= StRedirect;
                redirect_q <= 1'b1;
                flush_if_q <= 1'b1;
                flush_id_q <= ~DELAY_SLOT;
              end
            end
          end
        end
        StStall: begin
          cnt_q <= (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_q <= StIdle;
        end
        StRedirect: begin
          // Any request here sits in the delay slot and is dropped.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pc_redirect = redirect_q;
  assign pc_target   = target_q;
  assign flush_if    = flush_if_q;
  assign flush_id    = flush_id_q;
  assign br_cnt      = br_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl. Two instances share the stimulus: "dut" in
// the default build (delay slot, 16-bit counters) and "dut0" with no delay
// slot and 4-bit counters, for the flush_id and saturation cases.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  branch_cond;
  logic        jump;
  logic [31:0] id_pc4;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [4:0]  rs, rt;
  logic [31:0] rf_a, rf_b;
  logic        ex_wr_en, ex_is_load;
  logic [4:0]  ex_wr_addr;
  logic        mem_wr_en, mem_is_load;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_result;

  logic        stall, bubble_ex, pc_redirect, flush_if, flush_id;
  logic [31:0] pc_target;
  logic [15:0] br_cnt, taken_cnt;

  logic        s_stall, s_bubble_ex, s_pc_redirect, s_flush_if, s_flush_id;
  logic [31:0] s_pc_target;
  logic [3:0]  s_br_cnt, s_taken_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.DELAY_SLOT(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .branch_cond(branch_cond), .jump(jump),
    .id_pc4(id_pc4), .imm(imm), .jaddr(jaddr), .rs(rs), .rt(rt), .rf_a(rf_a), .rf_b(rf_b),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
    .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wr_addr(mem_wr_addr),
    .mem_result(mem_result), .stall(stall), .bubble_ex(bubble_ex),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush_if(flush_if),
    .flush_id(flush_id), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  branch_ctrl #(.DELAY_SLOT(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .branch_cond(branch_cond), .jump(jump),
    .id_pc4(id_pc4), .imm(imm), .jaddr(jaddr), .rs(rs), .rt(rt), .rf_a(rf_a), .rf_b(rf_b),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
    .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wr_addr(mem_wr_addr),
    .mem_result(mem_result), .stall(s_stall), .bubble_ex(s_bubble_ex),
    .pc_redirect(s_pc_redirect), .pc_target(s_pc_target), .flush_if(s_flush_if),
    .flush_id(s_flush_id), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_valid = 1'b0; branch_cond = 3'd0; jump = 1'b0; id_pc4 = 32'd0; imm = 16'd0;
    jaddr = 26'd0; rs = 5'd0; rt = 5'd0; rf_a = 32'd0; rf_b = 32'd0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = 5'd0;
    mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_wr_addr = 5'd0; mem_result = 32'd0;
  endtask

  task automatic set_br(input logic [2:0] c, input logic [4:0] s, input logic [4:0] t,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc4, input logic [15:0] im);
    id_valid = 1'b1; branch_cond = c; rs = s; rt = t;
    rf_a = a; rf_b = b; id_pc4 = pc4; imm = im;
  endtask

  task automatic check_counts(input string tag, input logic [31:0] br, input logic [31:0] tk);
    check({tag, "_br"}, 32'(br_cnt), br);
    check({tag, "_taken"}, 32'(taken_cnt), tk);
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    tick();
    tick();

    // Reset state
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bubble", 32'(bubble_ex), 32'd0);
    check("rst_redirect", 32'(pc_redirect), 32'd0);
    check("rst_target", pc_target, 32'd0);
    check("rst_flush_if", 32'(flush_if), 32'd0);
    check("rst_flush_id0", 32'(s_flush_id), 32'd0);
    check_counts("rst", 32'd0, 32'd0);
    rst = 1'b0;
    tick();

    // beq taken, no hazard: 0x100 + (4 << 2) = 0x110
    set_br(3'd1, 5'd1, 5'd2, 32'h1234, 32'h1234, 32'h100, 16'h0004);
    #1 check("beq_nostall", 32'(stall), 32'd0);
    tick();
    clear_in();
    check("beq_redirect", 32'(pc_redirect), 32'd1);
    check("beq_target", pc_target, 32'h110);
    check("beq_flush_if", 32'(flush_if), 32'd1);
    check("beq_flush_id", 32'(flush_id), 32'd0);
    check("beq_flush_id_nods", 32'(s_flush_id), 32'd1);
    check_counts("beq", 32'd1, 32'd1);
    tick();
    check("beq_redirect_done", 32'(pc_redirect), 32'd0);

    // bne, rs produced by an EX load: two stall cycles, then taken
    set_br(3'd2, 5'd3, 5'd4, 32'd5, 32'd6, 32'h200, 16'h0001);
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd3;
    #1 check("exld_stall1", 32'(stall), 32'd1);
    check("exld_bubble1", 32'(bubble_ex), 32'd1);
    tick();
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_wr_addr = 5'd3;
    #1 check("exld_stall2", 32'(stall), 32'd1);
    check("exld_bubble2", 32'(bubble_ex), 32'd1);
    tick();
    mem_wr_en = 1'b0; mem_is_load = 1'b0;
    #1 check("exld_stall3", 32'(stall), 32'd0);
    check("exld_bubble3", 32'(bubble_ex), 32'd0);
    check("exld_noredirect_yet", 32'(pc_redirect), 32'd0);
    tick();
    clear_in();
    check("exld_redirect", 32'(pc_redirect), 32'd1);
    check("exld_target", pc_target, 32'h204);
    check_counts("exld", 32'd2, 32'd2);
    tick();

    // bne, rt produced by an EX ALU op: one stall cycle, then forwarded, not taken
    set_br(3'd2, 5'd3, 5'd4, 32'd7, 32'd0, 32'h300, 16'h0010);
    ex_wr_en = 1'b1; ex_wr_addr = 5'd4;
    #1 check("exalu_stall1", 32'(stall), 32'd1);
    tick();
    ex_wr_en = 1'b0;
    mem_wr_en = 1'b1; mem_wr_addr = 5'd4; mem_result = 32'd7;
    #1 check("exalu_stall2", 32'(stall), 32'd0);
    tick();
    clear_in();
    check("exalu_noredirect", 32'(pc_redirect), 32'd0);
    check_counts("exalu", 32'd3, 32'd2);

    // bgtz with rs forwarded negative from MEM; rt hazard ignored for bgtz
    set_br(3'd4, 5'd5, 5'd9, 32'd1, 32'd0, 32'h400, 16'h0008);
    mem_wr_en = 1'b1; mem_wr_addr = 5'd5; mem_result = 32'h8000_0000;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd9;
    #1 check("bgtz_nostall", 32'(stall), 32'd0);
    tick();
    clear_in();
    check("bgtz_noredirect", 32'(pc_redirect), 32'd0);
    check_counts("bgtz", 32'd4, 32'd2);

    // Jump beats a hazarded branch and never stalls
    set_br(3'd1, 5'd6, 5'd0, 32'd0, 32'd0, 32'hA000_0004, 16'h0000);
    jump = 1'b1; jaddr = 26'h3FF_FFFF;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd6;
    #1 check("jump_nostall", 32'(stall), 32'd0);
    tick();
    clear_in();
    check("jump_redirect", 32'(pc_redirect), 32'd1);
    check("jump_target", pc_target, 32'hAFFF_FFFC);
    check("jump_flush_id", 32'(flush_id), 32'd0);
    check("jump_flush_id_nods", 32'(s_flush_id), 32'd1);
    check_counts("jump", 32'd4, 32'd3);
    tick();

    // Negative offset wraps; a branch in the redirect cycle is dropped
    set_br(3'd1, 5'd1, 5'd2, 32'd9, 32'd9, 32'h4, 16'h8000);
    tick();
    set_br(3'd1, 5'd7, 5'd2, 32'd1, 32'd1, 32'h1000, 16'h0001);
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd7;
    #1 check("wrap_redirect", 32'(pc_redirect), 32'd1);
    check("wrap_target", pc_target, 32'hFFFE_0004);
    check("slot_nostall", 32'(stall), 32'd0);
    check_counts("wrap", 32'd5, 32'd4);
    tick();
    clear_in();
    check("slot_noredirect", 32'(pc_redirect), 32'd0);
    check("slot_target_kept", pc_target, 32'hFFFE_0004);
    check_counts("slot", 32'd5, 32'd4);

    // Reset asserted in the middle of a stall
    set_br(3'd2, 5'd3, 5'd4, 32'd5, 32'd6, 32'h200, 16'h0001);
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd3;
    tick();
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_wr_addr = 5'd3;
    #1 check("midrst_stall_before", 32'(stall), 32'd1);
    rst = 1'b1;
    #1 check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_bubble", 32'(bubble_ex), 32'd0);
    check("midrst_redirect", 32'(pc_redirect), 32'd0);
    check("midrst_target", pc_target, 32'd0);
    check_counts("midrst", 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    clear_in();
    tick();
    check("postrst_stall", 32'(stall), 32'd0);
    check_counts("postrst", 32'd0, 32'd0);

    // 20 taken branches: 16-bit counters reach 20, 4-bit ones hold at 0xF
    for (int i = 0; i < 20; i++) begin
      set_br(3'd1, 5'd1, 5'd2, 32'h55, 32'h55, 32'h100, 16'h0004);
      tick();
      clear_in();
      tick();
    end
    check_counts("sat16", 32'd20, 32'd20);
    check("sat4_br", 32'(s_br_cnt), 32'hF);
    check("sat4_taken", 32'(s_taken_cnt), 32'hF);

    // Remaining single-operand conditions
    set_br(3'd3, 5'd8, 5'd0, 32'd0, 32'd0, 32'h800, 16'hFFFF);
    tick();
    clear_in();
    check("blez_redirect", 32'(pc_redirect), 32'd1);
    check("blez_target", pc_target, 32'h7FC);
    tick();
    set_br(3'd5, 5'd8, 5'd0, 32'd1, 32'd0, 32'h800, 16'h0001);
    tick();
    clear_in();
    check("bltz_noredirect", 32'(pc_redirect), 32'd0);
    set_br(3'd6, 5'd8, 5'd0, 32'h8000_0000, 32'd0, 32'h800, 16'h0001);
    tick();
    clear_in();
    check("bgez_noredirect", 32'(pc_redirect), 32'd0);
    check_counts("cond", 32'd23, 32'd21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
